ex2_lane_complete: RTL

Parametrised EX2 completion stage for the multi-lane core. It takes up to LANES micro-ops that EX1 has already issued and waits for each lane's slow unit (memory, multiplier, FPU) to finish. It captures each lane's finished result while other lanes are still stalled, and drives one pipeline-wide exHold. It sits between EX1 and the register-file writeback, replacing the single-lane EX2 hold logic.

---
 rtl/ex2_lane_complete_pkg.sv | 90 +++++++++
 rtl/ex2_lane_slot.sv | 121 ++++++++++++
 rtl/ex2_lane_complete.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ex2_lane_complete_pkg.sv
// Shared definitions for the EX2 multi-lane completion stage:
// micro-op command codes, predicate modes, memory/FPU status codes, the null
// register ID, the lane class / slot state enums and the command decoders.
package ex2_lane_complete_pkg;

  localparam int unsigned CMD_W = 6;
  localparam int unsigned GR_W  = 6;

  // Null destination register: writes to it are discarded by writeback.
  localparam logic [GR_W-1:0] JX2_GR_ZZR = 6'h3F;

  // Memory / FPU status codes. Bit 1 set means "not finished yet".
  localparam logic [1:0] UMEM_OK_READY = 2'b00;
  localparam logic [1:0] UMEM_OK_OK    = 2'b01;
  localparam logic [1:0] UMEM_OK_HOLD  = 2'b10;
  localparam logic [1:0] UMEM_OK_FAULT = 2'b11;

  // Micro-op commands (opUCmd[5:0]); anything not listed decodes as NOP.
  localparam logic [CMD_W-1:0] JX2_UCMD_NOP    = 6'h00;
  localparam logic [CMD_W-1:0] JX2_UCMD_ALU3   = 6'h01;
  localparam logic [CMD_W-1:0] JX2_UCMD_UNARY  = 6'h02;
  localparam logic [CMD_W-1:0] JX2_UCMD_MOV_MR = 6'h03;
  localparam logic [CMD_W-1:0] JX2_UCMD_POPX   = 6'h04;
  localparam logic [CMD_W-1:0] JX2_UCMD_MOV_RM = 6'h05;
  localparam logic [CMD_W-1:0] JX2_UCMD_PUSHX  = 6'h06;
  localparam logic [CMD_W-1:0] JX2_UCMD_MUL3   = 6'h07;
  localparam logic [CMD_W-1:0] JX2_UCMD_FPU3   = 6'h08;
  localparam logic [CMD_W-1:0] JX2_UCMD_FIXS   = 6'h09;

  // Predicate modes (opUCmd[7:6]).
  localparam logic [1:0] PRED_ALWAYS = 2'b00;
  localparam logic [1:0] PRED_NEVER  = 2'b01;
  localparam logic [1:0] PRED_T      = 2'b10;
  localparam logic [1:0] PRED_NT     = 2'b11;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LD,
    CLS_ST,
    CLS_MUL,
    CLS_FPU
  } ex2_cls_e;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_WAIT,
    SLOT_DONE
  } slot_state_e;

  // One lane's micro-op byte.
  typedef struct packed {
    logic [1:0]       pred;
    logic [CMD_W-1:0] cmd;
  } ucmd_t;

  function automatic ex2_cls_e decode_cls(input logic [CMD_W-1:0] cmd);
    ex2_cls_e cls;
    cls = CLS_NOP;
    case (cmd)
      JX2_UCMD_ALU3, JX2_UCMD_UNARY:  cls = CLS_ALU;
      JX2_UCMD_MOV_MR, JX2_UCMD_POPX: cls = CLS_LD;
      JX2_UCMD_MOV_RM, JX2_UCMD_PUSHX: cls = CLS_ST;
      JX2_UCMD_MUL3:                  cls = CLS_MUL;
      JX2_UCMD_FPU3, JX2_UCMD_FIXS:   cls = CLS_FPU;
      default:                        cls = CLS_NOP;
    endcase
    return cls;
  endfunction

  function automatic logic pred_enable(input logic [1:0] pm, input logic t);
    logic en;
    case (pm)
      PRED_ALWAYS: en = 1'b1;
      PRED_NEVER:  en = 1'b0;
      PRED_T:      en = t;
      default:     en = !t;
    endcase
    return en;
  endfunction

  function automatic logic is_mem(input ex2_cls_e cls);
    return (cls == CLS_LD) || (cls == CLS_ST);
  endfunction

  function automatic logic cls_writes(input ex2_cls_e cls);
    return (cls == CLS_ALU) || (cls == CLS_LD) || (cls == CLS_MUL) || (cls == CLS_FPU);
  endfunction

endpackage

// File: rtl/ex2_lane_slot.sv
// One EX2 lane: completion check, IDLE/WAIT/DONE FSM and the capture buffer
// that holds a finished result while other lanes keep the pipeline stalled.
// Ports:
//   clock, reset      core clock, synchronous active-high reset
//   cls_i             lane class, already masked by predication/flush
//   ex_hold_i         pipeline-wide hold (combinational, this cycle)
//   hold_cyc_i        shared hold cycle counter
//   mem_busy_i        memDataOK[1]; fpu_ok_i FPU status; mul_ext_i opUIxt[1:0]
//   id_i, *_i         destination ID and candidate results
//   hold_req_c_o      lane still needs the pipeline held
//   wb_id_c_o/val_c_o writeback ID/value (buffer when DONE, else live)
// Build option: JX2_EX2_LD1CYC_EN lets LD/ST finish in their first cycle.
module ex2_lane_slot
  import ex2_lane_complete_pkg::*;
#(
  parameter int unsigned DW      = 64,
  parameter int unsigned HCW     = 4,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  ex2_cls_e        cls_i,
  input  logic            ex_hold_i,
  input  logic [HCW-1:0]  hold_cyc_i,
  input  logic            mem_busy_i,
  input  logic [1:0]      fpu_ok_i,
  input  logic [1:0]      mul_ext_i,
  input  logic [GR_W-1:0] id_i,
  input  logic [DW-1:0]   alu_i,
  input  logic [DW-1:0]   mul_i,
  input  logic [DW-1:0]   fpu_i,
  input  logic [DW-1:0]   mem_i,
  output logic            hold_req_c_o,
  output logic [GR_W-1:0] wb_id_c_o,
  output logic [DW-1:0]   wb_val_c_o
);

  slot_state_e     state_q, state_d;
  logic [GR_W-1:0] cap_id_q, cap_id_d;
  logic [DW-1:0]   cap_val_q, cap_val_d;
  logic            complete_c;
  logic [GR_W-1:0] live_id_c;
  logic [DW-1:0]   live_val_c;

  // Per-class completion test.
  always_comb begin
    complete_c = 1'b1;
    case (cls_i)
      CLS_NOP, CLS_ALU: complete_c = 1'b1;
      CLS_MUL:          complete_c = (hold_cyc_i == HCW'(MUL_LAT));
      CLS_FPU:          complete_c = (fpu_ok_i == UMEM_OK_OK);
`ifdef JX2_EX2_LD1CYC_EN
      CLS_LD, CLS_ST:   complete_c = !mem_busy_i;
`else
      // First cycle of a memory op always stalls (minimum latency of one).
      CLS_LD, CLS_ST:   complete_c = !mem_busy_i && (hold_cyc_i != '0);
`endif
      default:          complete_c = 1'b1;
    endcase
  end

  // Live result select; MUL narrows to 32 bits unless ixt asks for the full product.
  always_comb begin
    live_val_c = '0;
    case (cls_i)
      CLS_ALU: live_val_c = alu_i;
      CLS_LD:  live_val_c = mem_i;
      CLS_FPU: live_val_c = fpu_i;
      CLS_MUL: begin
        case (mul_ext_i)
          2'b00:   live_val_c = DW'($signed(mul_i[31:0]));
          2'b01:   live_val_c = DW'(mul_i[31:0]);
          default: live_val_c = mul_i;
        endcase
      end
      default: live_val_c = '0;
    endcase
    live_id_c = cls_writes(cls_i) ? id_i : JX2_GR_ZZR;
  end

  // Next state: capture on completion while someone else still holds.
  always_comb begin
    state_d   = state_q;
    cap_id_d  = cap_id_q;
    cap_val_d = cap_val_q;
    case (state_q)
      SLOT_IDLE, SLOT_WAIT: begin
        if (!ex_hold_i) begin
          state_d = SLOT_IDLE;
        end else if (complete_c) begin
          state_d   = SLOT_DONE;
          cap_id_d  = live_id_c;
          cap_val_d = live_val_c;
        end else begin
          state_d = SLOT_WAIT;
        end
      end
      SLOT_DONE: begin
        if (!ex_hold_i) state_d = SLOT_IDLE;
      end
      default: state_d = SLOT_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= SLOT_IDLE;
      cap_id_q  <= JX2_GR_ZZR;
      cap_val_q <= '0;
    end else begin
      state_q   <= state_d;
      cap_id_q  <= cap_id_d;
      cap_val_q <= cap_val_d;
    end
  end

  assign hold_req_c_o = !complete_c && (state_q != SLOT_DONE);
  assign wb_id_c_o    = (state_q == SLOT_DONE) ? cap_id_q  : live_id_c;
  assign wb_val_c_o   = (state_q == SLOT_DONE) ? cap_val_q : live_val_c;

endmodule

// File: rtl/ex2_lane_complete.sv
// EX2 completion stage for LANES parallel micro-ops: decodes/predicates each
// lane, runs one ex2_lane_slot per lane, raises the shared exHold, keeps the
// hold cycle counter and the sticky fault/timeout flags, and registers the
// writeback ID/value for every lane.
// Ports:
//   clock, reset        core clock, synchronous active-high reset
//   opUCmd, opUIxt      per-lane micro-op and extended bits (8 bits each)
//   opBraFlush          disables every lane
//   regInLastSr         SR snapshot, bit 0 = T for predication
//   regIdRm             per-lane destination IDs
//   regValAluRes/MulRes/regFpuGRn, regFpuOK  per-lane unit results/status
//   memDataIn, memDataOK  load data and status (lane 0 only)
//   exHold              combinational stall request
//   regIdRn2, regValRn2 registered writeback IDs/values
//   exFault, exTimeout  sticky flags
// Build option: JX2_EX2_LD1CYC_EN (single-cycle LD/ST completion).
module ex2_lane_complete
  import ex2_lane_complete_pkg::*;
#(
  parameter int unsigned LANES    = 2,
  parameter int unsigned DW       = 64,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [8*LANES-1:0]   opUCmd,
  input  logic [8*LANES-1:0]   opUIxt,
  input  logic                 opBraFlush,
  input  logic [7:0]           regInLastSr,
  input  logic [6*LANES-1:0]   regIdRm,
  input  logic [DW*LANES-1:0]  regValAluRes,
  input  logic [DW*LANES-1:0]  regValMulRes,
  input  logic [DW*LANES-1:0]  regFpuGRn,
  input  logic [2*LANES-1:0]   regFpuOK,
  input  logic [DW-1:0]        memDataIn,
  input  logic [1:0]           memDataOK,
  output logic                 exHold,
  output logic [6*LANES-1:0]   regIdRn2,
  output logic [DW*LANES-1:0]  regValRn2,
  output logic                 exFault,
  output logic                 exTimeout
);

  localparam int unsigned HCW = $clog2(HOLD_MAX + 1);

  logic [HCW-1:0]        hold_cyc_q, hold_cyc_d;
  logic                  ex_fault_q, ex_fault_d;
  logic                  ex_timeout_q, ex_timeout_d;
  logic [6*LANES-1:0]    reg_id_rn2_q, reg_id_rn2_d;
  logic [DW*LANES-1:0]   reg_val_rn2_q, reg_val_rn2_d;
  logic [LANES-1:0]      hold_req_c;
  logic [6*LANES-1:0]    wb_id_c;
  logic [DW*LANES-1:0]   wb_val_c;
  logic                  lane0_mem_c;
  logic                  unused_inputs;

  // Only T and ixt[1:0] are consumed here.
  assign unused_inputs = ^{regInLastSr[7:1], opUIxt};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ucmd_t    ucmd;
    ex2_cls_e raw_cls;
    ex2_cls_e cls;
    logic     en;

    assign ucmd    = opUCmd[8*i +: 8];
    assign en      = pred_enable(ucmd.pred, regInLastSr[0]) && !opBraFlush;
    assign raw_cls = decode_cls(ucmd.cmd);

    // Memory ports exist only on lane 0; elsewhere a memory op becomes a NOP.
    always_comb begin
      cls = CLS_NOP;
      if (en && !((i != 0) && is_mem(raw_cls))) cls = raw_cls;
    end

    if (i == 0) begin : g_lane0
      assign lane0_mem_c = is_mem(cls);
    end else begin : g_memchk
`ifndef SYNTHESIS
      always_ff @(posedge clock) begin
        if (!reset && en && is_mem(raw_cls))
          $warning("ex2_lane_complete: memory op on lane %0d dropped", i);
      end
`endif
    end

    ex2_lane_slot #(
      .DW      (DW),
      .HCW     (HCW),
      .MUL_LAT (MUL_LAT)
    ) u_slot (
      .clock        (clock),
      .reset        (reset),
      .cls_i        (cls),
      .ex_hold_i    (exHold),
      .hold_cyc_i   (hold_cyc_q),
      .mem_busy_i   (memDataOK[1]),
      .fpu_ok_i     (regFpuOK[2*i +: 2]),
      .mul_ext_i    (opUIxt[8*i +: 2]),
      .id_i         (regIdRm[6*i +: 6]),
      .alu_i        (regValAluRes[DW*i +: DW]),
      .mul_i        (regValMulRes[DW*i +: DW]),
      .fpu_i        (regFpuGRn[DW*i +: DW]),
      .mem_i        (memDataIn),
      .hold_req_c_o (hold_req_c[i]),
      .wb_id_c_o    (wb_id_c[6*i +: 6]),
      .wb_val_c_o   (wb_val_c[DW*i +: DW])
    );
  end

  // A latched fault keeps the pipeline stalled; reset drops the hold at once.
  assign exHold = !reset && ((|hold_req_c) || ex_fault_q);

  always_comb begin
    hold_cyc_d    = '0;
    ex_fault_d    = ex_fault_q;
    ex_timeout_d  = ex_timeout_q;
    reg_id_rn2_d  = {LANES{JX2_GR_ZZR}};
    reg_val_rn2_d = '0;

    if (exHold) begin
      hold_cyc_d = (hold_cyc_q == HCW'(HOLD_MAX)) ? hold_cyc_q : hold_cyc_q + HCW'(1);
    end
    if (lane0_mem_c && (memDataOK == UMEM_OK_FAULT)) ex_fault_d = 1'b1;
    if (hold_cyc_d == HCW'(HOLD_MAX)) ex_timeout_d = 1'b1;

    // All lanes write back together or not at all.
    if (!exHold) begin
      reg_id_rn2_d  = wb_id_c;
      reg_val_rn2_d = wb_val_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cyc_q    <= '0;
      ex_fault_q    <= 1'b0;
      ex_timeout_q  <= 1'b0;
      reg_id_rn2_q  <= {LANES{JX2_GR_ZZR}};
      reg_val_rn2_q <= '0;
    end else begin
      hold_cyc_q    <= hold_cyc_d;
      ex_fault_q    <= ex_fault_d;
      ex_timeout_q  <= ex_timeout_d;
      reg_id_rn2_q  <= reg_id_rn2_d;
      reg_val_rn2_q <= reg_val_rn2_d;
    end
  end

  assign regIdRn2  = reg_id_rn2_q;
  assign regValRn2 = reg_val_rn2_q;
  assign exFault   = ex_fault_q;
  assign exTimeout = ex_timeout_q;

endmodule
